rst_sequencer: RTL and testbench

Staged reset release for the core and its peripherals, one stage downstream of the simulation clock/reset generator. The harness inverts the generator's active-high reset onto `rst_ni`. This block synchronises the deassertion of that reset and releases `NumStages` active-low reset outputs one after another at fixed spacing. It also supports a software-requested warm reset that re-runs the release sequence.

---
 rtl/rst_seq_pkg.sv | 26 ++
 rtl/rst_sync.sv | 25 ++
 rtl/rst_sequencer.sv | 173 +++++++++++++++++
 tb/tb_rst_sequencer.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/rst_seq_pkg.sv
// Shared types and defaults for the staged reset sequencer.
//   rst_seq_state_e : sequencer FSM states (HOLD, RELEASE, RUN, SOFT)
//   Def*            : default parameter values for rst_sequencer
//   max_u           : unsigned maximum, used to size the shared delay counter
package rst_seq_pkg;

    typedef enum logic [1:0] {
        StHold    = 2'd0,
        StRelease = 2'd1,
        StRun     = 2'd2,
        StSoft    = 2'd3
    } rst_seq_state_e;

    localparam int unsigned DefNumStages      = 3;
    localparam int unsigned DefSyncStages     = 2;
    localparam int unsigned DefStageDelay     = 4;
    localparam int unsigned DefSoftHoldCycles = 8;
`ifdef RST_SEQ_WDT_EN
    localparam int unsigned DefWdtTimeout     = 32;
`endif

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rst_sync.sv
// Reset synchroniser: asynchronous assertion, synchronous deassertion.
//   clk_i  : clock
//   rst_ni : asynchronous active-low reset in
//   sync_o : high once SyncStages edges have seen rst_ni deasserted
module rst_sync #(
    parameter int unsigned SyncStages = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    output logic sync_o
);

    logic [SyncStages-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SyncStages-2:0], 1'b1};
        end
    end

    assign sync_o = sync_q[SyncStages-1];

endmodule

// File: rtl/rst_sequencer.sv
// Staged reset release: synchronises rst_ni deassertion, then releases NumStages
// active-low resets one after another every StageDelay cycles. A warm reset
// (soft_req_i in RUN) re-asserts everything for SoftHoldCycles and re-runs the release.
//   clk_i       : clock
//   rst_ni      : asynchronous active-low reset
//   soft_req_i  : warm-reset request (level), honoured only in RUN
//   soft_ack_o  : one-cycle pulse when the warm-reset hold ends
//   rst_no      : sequenced active-low resets, bit 0 released first
//   ready_o     : high while all stages are released
// Optional build macro RST_SEQ_WDT_EN adds a watchdog:
//   kick_i      : clears the watchdog counter
//   wdt_fired_o : sticky flag, set when the watchdog forces a warm reset
module rst_sequencer
    import rst_seq_pkg::*;
#(
    parameter int unsigned NumStages      = DefNumStages,
    parameter int unsigned SyncStages     = DefSyncStages,
    parameter int unsigned StageDelay     = DefStageDelay,
    parameter int unsigned SoftHoldCycles = DefSoftHoldCycles
`ifdef RST_SEQ_WDT_EN
    ,
    parameter int unsigned WdtTimeout     = DefWdtTimeout
`endif
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 soft_req_i,
`ifdef RST_SEQ_WDT_EN
    input  logic                 kick_i,
    output logic                 wdt_fired_o,
`endif
    output logic                 soft_ack_o,
    output logic [NumStages-1:0] rst_no,
    output logic                 ready_o
);

    localparam int unsigned CntW = $clog2(max_u(StageDelay, SoftHoldCycles) + 1);
    localparam int unsigned IdxW = (NumStages > 1) ? $clog2(NumStages) : 1;

    localparam logic [CntW-1:0] StageLast = CntW'(StageDelay - 1);
    localparam logic [CntW-1:0] SoftLast  = CntW'(SoftHoldCycles - 1);
    localparam logic [IdxW-1:0] IdxLast   = IdxW'(NumStages - 1);

    logic sync;

    rst_sync #(
        .SyncStages(SyncStages)
    ) u_rst_sync (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .sync_o(sync)
    );

    rst_seq_state_e       state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [IdxW-1:0]      idx_q, idx_d;
    logic [NumStages-1:0] rst_q, rst_d;
    logic                 ready_q, ready_d;
    logic                 ack_q, ack_d;
    logic                 enter_soft;

`ifdef RST_SEQ_WDT_EN
    localparam int unsigned WdtW = (WdtTimeout > 1) ? $clog2(WdtTimeout) : 1;
    localparam logic [WdtW-1:0] WdtLast = WdtW'(WdtTimeout - 1);

    logic [WdtW-1:0] wdt_q, wdt_d;
    logic            fired_q, fired_d;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        rst_d      = rst_q;
        ready_d    = ready_q;
        ack_d      = 1'b0;
        enter_soft = 1'b0;
`ifdef RST_SEQ_WDT_EN
        wdt_d      = '0;
        fired_d    = fired_q;
`endif

        unique case (state_q)
            // The HOLD edge that first sees sync high already counts as the first
            // delay cycle, so stage 0 releases SyncStages+StageDelay edges after reset.
            StHold, StRelease: begin
                if (state_q == StRelease || sync) begin
                    state_d = StRelease;
                    if (cnt_q == StageLast) begin
                        rst_d[idx_q] = 1'b1;
                        cnt_d        = '0;
                        if (idx_q == IdxLast) begin
                            state_d = StRun;
                            ready_d = 1'b1;
                            idx_d   = '0;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StRun: begin
                if (soft_req_i) begin
                    enter_soft = 1'b1;
`ifdef RST_SEQ_WDT_EN
                end else if (!kick_i && wdt_q == WdtLast) begin
                    // soft_req_i has priority; the flag is only set on a true timeout
                    enter_soft = 1'b1;
                    fired_d    = 1'b1;
                end else if (!kick_i) begin
                    wdt_d = wdt_q + 1'b1;
`endif
                end
                if (enter_soft) begin
                    state_d = StSoft;
                    rst_d   = '0;
                    ready_d = 1'b0;
                    cnt_d   = '0;
                end
            end
            StSoft: begin
                if (cnt_q == SoftLast) begin
                    state_d = StRelease;
                    idx_d   = '0;
                    cnt_d   = '0;
                    ack_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StHold;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StHold;
            cnt_q   <= '0;
            idx_q   <= '0;
            rst_q   <= '0;
            ready_q <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            rst_q   <= rst_d;
            ready_q <= ready_d;
            ack_q   <= ack_d;
        end
    end

`ifdef RST_SEQ_WDT_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wdt_q   <= '0;
            fired_q <= 1'b0;
        end else begin
            wdt_q   <= wdt_d;
            fired_q <= fired_d;
        end
    end

    assign wdt_fired_o = fired_q;
`endif

    assign rst_no     = rst_q;
    assign ready_o    = ready_q;
    assign soft_ack_o = ack_q;

endmodule

// File: tb/tb_rst_sequencer.sv
// Directed bench for rst_sequencer with default parameters. Edge numbers count
// rising edges after rst_ni rises; outputs are sampled 1ns after each edge.
module tb_rst_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       soft_req = 1'b0;
    logic       soft_ack;
    logic [2:0] rst_no;
    logic       ready;
`ifdef RST_SEQ_WDT_EN
    logic       kick = 1'b0;
    logic       wdt_fired;
`endif

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned edge_n = 0;

    typedef struct {
        int unsigned edge_n;
        logic        req;
        logic [2:0]  rst;
        logic        rdy;
        logic        ack;
    } vec_t;

    vec_t vq[$];

    always #5 clk = ~clk;

    rst_sequencer dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .soft_req_i (soft_req),
`ifdef RST_SEQ_WDT_EN
        .kick_i     (kick),
        .wdt_fired_o(wdt_fired),
`endif
        .soft_ack_o (soft_ack),
        .rst_no     (rst_no),
        .ready_o    (ready)
    );

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %b, expected %b", name, edge_n, act, exp);
        end
    endtask

    task automatic check_out(input string name, input logic [2:0] r, input logic rd,
                             input logic ak);
        check(name, {3'b000, rst_no, ready, soft_ack}, {3'b000, r, rd, ak});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        edge_n++;
    endtask

    task automatic run_to(input int unsigned n);
        while (edge_n < n) step();
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        soft_req = 1'b0;
`ifdef RST_SEQ_WDT_EN
        kick     = 1'b0;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        edge_n = 0;
    endtask

    initial begin
        // Reset state, with a request present that must be ignored
        soft_req = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_out("reset_state", 3'b000, 1'b0, 1'b0);

        // Power-on sequence plus warm reset at edge 20; request at 8 falls in RELEASE
        vq.push_back('{1,  1'b0, 3'b000, 1'b0, 1'b0});
        vq.push_back('{2,  1'b0, 3'b000, 1'b0, 1'b0});
        vq.push_back('{5,  1'b0, 3'b000, 1'b0, 1'b0});
        vq.push_back('{6,  1'b0, 3'b001, 1'b0, 1'b0});
        vq.push_back('{8,  1'b1, 3'b001, 1'b0, 1'b0});
        vq.push_back('{9,  1'b0, 3'b001, 1'b0, 1'b0});
        vq.push_back('{10, 1'b0, 3'b011, 1'b0, 1'b0});
        vq.push_back('{13, 1'b0, 3'b011, 1'b0, 1'b0});
        vq.push_back('{14, 1'b0, 3'b111, 1'b1, 1'b0});
        vq.push_back('{19, 1'b0, 3'b111, 1'b1, 1'b0});
        vq.push_back('{20, 1'b1, 3'b000, 1'b0, 1'b0});
        vq.push_back('{21, 1'b0, 3'b000, 1'b0, 1'b0});
        vq.push_back('{27, 1'b0, 3'b000, 1'b0, 1'b0});
        vq.push_back('{28, 1'b0, 3'b000, 1'b0, 1'b1});
        vq.push_back('{29, 1'b0, 3'b000, 1'b0, 1'b0});
        vq.push_back('{31, 1'b0, 3'b000, 1'b0, 1'b0});
        vq.push_back('{32, 1'b0, 3'b001, 1'b0, 1'b0});
        vq.push_back('{36, 1'b0, 3'b011, 1'b0, 1'b0});
        vq.push_back('{39, 1'b0, 3'b011, 1'b0, 1'b0});
        vq.push_back('{40, 1'b0, 3'b111, 1'b1, 1'b0});

        do_reset();
        for (int i = 0; i < vq.size(); i++) begin
            soft_req = 1'b0;
            run_to(vq[i].edge_n - 1);
            soft_req = vq[i].req;
            step();
            soft_req = 1'b0;
            check_out($sformatf("vec%0d", i), vq[i].rst, vq[i].rdy, vq[i].ack);
        end

        // Asynchronous reset pulse between edges 11 and 12
        do_reset();
        run_to(11);
        check_out("pre_pulse", 3'b011, 1'b0, 1'b0);
        #1 rst_n = 1'b0;
        #1 check_out("async_assert", 3'b000, 1'b0, 1'b0);
        @(negedge clk);
        rst_n  = 1'b1;
        edge_n = 0;
        run_to(5);
        check_out("restart_e5", 3'b000, 1'b0, 1'b0);
        run_to(6);
        check_out("restart_e6", 3'b001, 1'b0, 1'b0);
        run_to(13);
        check_out("restart_e13", 3'b011, 1'b0, 1'b0);
        run_to(14);
        check_out("restart_e14", 3'b111, 1'b1, 1'b0);

        // Request held high through the ack: second warm reset on RUN re-entry + 1
        run_to(15);
        soft_req = 1'b1;
        run_to(16);
        check_out("held_enter", 3'b000, 1'b0, 1'b0);
        run_to(24);
        check_out("held_ack", 3'b000, 1'b0, 1'b1);
        run_to(28);
        check_out("held_rel0", 3'b001, 1'b0, 1'b0);
        run_to(36);
        check_out("held_run", 3'b111, 1'b1, 1'b0);
        run_to(37);
        check_out("held_again", 3'b000, 1'b0, 1'b0);
        soft_req = 1'b0;
        run_to(45);
        check_out("held_ack2", 3'b000, 1'b0, 1'b1);
        run_to(49);
        check_out("held_rel0b", 3'b001, 1'b0, 1'b0);

`ifdef RST_SEQ_WDT_EN
        // No kicks: RUN at edge 14, watchdog forces a warm reset at edge 46
        do_reset();
        run_to(45);
        check("wdt_before", {5'b0, rst_no, 1'b0} | {7'b0, ready} | {6'b0, wdt_fired, 1'b0},
              8'b0000_1111 & {4'b0, 3'b111, 1'b1});
        run_to(46);
        check("wdt_fire_out", {3'b000, rst_no, ready, soft_ack}, 8'b0000_0000);
        check("wdt_fire_flag", {7'b0, wdt_fired}, 8'd1);
        run_to(60);
        check("wdt_sticky", {7'b0, wdt_fired}, 8'd1);
        do_reset();
        step();
        check("wdt_clear", {7'b0, wdt_fired}, 8'd0);
        // Kicking every 10 cycles keeps the block in RUN
        run_to(14);
        for (int k = 0; k < 100; k++) begin
            kick = ((edge_n % 10) == 9);
            step();
        end
        kick = 1'b0;
        check_out("wdt_kicked_out", 3'b111, 1'b1, 1'b0);
        check("wdt_kicked_flag", {7'b0, wdt_fired}, 8'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
